// File: rtl/password_writer_pkg.sv
// Shared definitions for the password store, its writer and the checker.
// The default code lives here so the reader and the writer never disagree.
package password_writer_pkg;

  localparam int PW_DIGITS = 4;
  localparam int DIGIT_W   = 4;
  localparam int ADDR_W    = 2;
  localparam int PW_W      = PW_DIGITS * DIGIT_W;

  // Digit i sits in bits [4i+3:4i], so this reads 1,2,3,4 from address 0 up.
  localparam logic [PW_W-1:0] DEFAULT_PW = 16'h4321;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ENTER1 = 2'd1,
    ENTER2 = 2'd2,
    COMMIT = 2'd3
  } pw_state_t;

endpackage

// File: rtl/password_writer_pw_store.sv
// 4x4 password register file: one synchronous write port, one registered read port.
// Read latency 1 cycle; no backpressure, the read port updates every cycle.
module pw_store
  import password_writer_pkg::*;
#(
  parameter logic [PW_W-1:0] INIT = DEFAULT_PW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [DIGIT_W-1:0] wr_data,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic [DIGIT_W-1:0] rd_data
);

  logic [PW_DIGITS-1:0][DIGIT_W-1:0] mem;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem     <= INIT;
      rd_data <= INIT[DIGIT_W-1:0];
    end else begin
      if (we) mem[wr_addr] <= wr_data;
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/password_writer.sv
// Password store owner: serves checker reads (1-cycle registered) and reprograms the code
// after a reconfig request via a double-entry confirm; store changes only on a matching pair.
module password_writer
  import password_writer_pkg::*;
#(
  parameter logic [PW_W-1:0] DEFAULT_PW     = password_writer_pkg::DEFAULT_PW,
  parameter logic [31:0]     TIMEOUT_CYCLES = 32'd50_000_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               reconfig,
  input  logic [DIGIT_W-1:0] pw,
  input  logic               pwButton,
  input  logic [ADDR_W-1:0]  rdAddr,
  output logic [DIGIT_W-1:0] rdData,
  output logic               busy,
  output logic [ADDR_W-1:0]  digitCount,
  output logic               confirmPhase,
  output logic               done,
  output logic               mismatch,
  output logic               abort
);

  pw_state_t                         state, state_nxt;
  logic [ADDR_W-1:0]                 digit_cnt, digit_cnt_nxt;
  logic [ADDR_W-1:0]                 commit_idx, commit_idx_nxt;
  logic [PW_DIGITS-1:0][DIGIT_W-1:0] shadow, shadow_nxt;
  logic                              mm_flag, mm_flag_nxt;
  logic [31:0]                       idle_cnt, idle_cnt_nxt;
  logic                              done_nxt, mismatch_nxt, abort_nxt;
  logic                              timeout_hit;
  logic                              flag_now;
  logic                              store_we;

  // idle_cnt holds the cycles elapsed since the last press or state entry,
  // counting the current one, so abort lands TIMEOUT_CYCLES cycles after a press.
  assign timeout_hit = (TIMEOUT_CYCLES != 32'd0) && (idle_cnt >= TIMEOUT_CYCLES - 32'd1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      digit_cnt  <= '0;
      commit_idx <= '0;
      shadow     <= '0;
      mm_flag    <= 1'b0;
      idle_cnt   <= '0;
      done       <= 1'b0;
      mismatch   <= 1'b0;
      abort      <= 1'b0;
    end else begin
      state      <= state_nxt;
      digit_cnt  <= digit_cnt_nxt;
      commit_idx <= commit_idx_nxt;
      shadow     <= shadow_nxt;
      mm_flag    <= mm_flag_nxt;
      idle_cnt   <= idle_cnt_nxt;
      done       <= done_nxt;
      mismatch   <= mismatch_nxt;
      abort      <= abort_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    digit_cnt_nxt  = digit_cnt;
    commit_idx_nxt = commit_idx;
    shadow_nxt     = shadow;
    mm_flag_nxt    = mm_flag;
    idle_cnt_nxt   = idle_cnt;
    done_nxt       = 1'b0;
    mismatch_nxt   = 1'b0;
    abort_nxt      = 1'b0;
    store_we       = 1'b0;
    flag_now       = mm_flag | (pw != shadow[digit_cnt]);

    case (state)
      IDLE: begin
        if (reconfig) begin
          state_nxt     = ENTER1;
          digit_cnt_nxt = '0;
          idle_cnt_nxt  = 32'd1;
        end
      end

      ENTER1: begin
        if (pwButton) begin
          shadow_nxt[digit_cnt] = pw;
          digit_cnt_nxt         = digit_cnt + 2'd1;
          idle_cnt_nxt          = 32'd1;
          if (digit_cnt == 2'd3) begin
            state_nxt   = ENTER2;
            mm_flag_nxt = 1'b0;
          end
        end else if (timeout_hit) begin
          state_nxt     = IDLE;
          digit_cnt_nxt = '0;
          abort_nxt     = 1'b1;
        end else begin
          idle_cnt_nxt = idle_cnt + 32'd1;
        end
      end

      ENTER2: begin
        if (pwButton) begin
          mm_flag_nxt   = flag_now;
          digit_cnt_nxt = digit_cnt + 2'd1;
          idle_cnt_nxt  = 32'd1;
          if (digit_cnt == 2'd3) begin
            if (flag_now) begin
              state_nxt    = ENTER1;
              mismatch_nxt = 1'b1;
            end else begin
              state_nxt      = COMMIT;
              commit_idx_nxt = '0;
            end
          end
        end else if (timeout_hit) begin
          state_nxt     = IDLE;
          digit_cnt_nxt = '0;
          abort_nxt     = 1'b1;
        end else begin
          idle_cnt_nxt = idle_cnt + 32'd1;
        end
      end

      COMMIT: begin
        store_we       = 1'b1;
        commit_idx_nxt = commit_idx + 2'd1;
        if (commit_idx == 2'd3) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  assign busy         = (state != IDLE);
  assign confirmPhase = (state == ENTER2);
  assign digitCount   = digit_cnt;

  pw_store #(
    .INIT (DEFAULT_PW)
  ) u_store (
    .clk     (clk),
    .rst     (rst),
    .we      (store_we),
    .wr_addr (commit_idx),
    .wr_data (shadow[commit_idx]),
    .rd_addr (rdAddr),
    .rd_data (rdData)
  );

endmodule

// File: tb/tb_password_writer.sv
// Directed-vector bench for password_writer with a short timeout so abort is reachable.
module tb_password_writer;

  logic       clk = 1'b0;
  logic       rst;
  logic       reconfig;
  logic [3:0] pw;
  logic       pwButton;
  logic [1:0] rdAddr;
  logic [3:0] rdData;
  logic       busy;
  logic [1:0] digitCount;
  logic       confirmPhase;
  logic       done;
  logic       mismatch;
  logic       abort;

  int n_vec = 0;
  int n_err = 0;

  password_writer #(
    .DEFAULT_PW     (16'h4321),
    .TIMEOUT_CYCLES (32'd10)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .reconfig     (reconfig),
    .pw           (pw),
    .pwButton     (pwButton),
    .rdAddr       (rdAddr),
    .rdData       (rdData),
    .busy         (busy),
    .digitCount   (digitCount),
    .confirmPhase (confirmPhase),
    .done         (done),
    .mismatch     (mismatch),
    .abort        (abort)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] d);
    pw       = d;
    pwButton = 1'b1;
    tick();
    pwButton = 1'b0;
  endtask

  // Four presses with a one-cycle gap between them; returns in the cycle after the last press.
  task automatic enter4(input logic [3:0] d0, input logic [3:0] d1,
                        input logic [3:0] d2, input logic [3:0] d3);
    press(d0); tick();
    press(d1); tick();
    press(d2); tick();
    press(d3);
  endtask

  task automatic pulse_reconfig();
    reconfig = 1'b1;
    tick();
    reconfig = 1'b0;
  endtask

  task automatic check_store(input string tag, input logic [15:0] exp);
    for (int a = 0; a < 4; a++) begin
      rdAddr = 2'(a);
      tick();
      check_eq(tag, 32'(rdData), 32'(exp[4*a +: 4]));
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_busy"},  32'(busy), 32'd0);
    check_eq({tag, "_cnt"},   32'(digitCount), 32'd0);
    check_eq({tag, "_conf"},  32'(confirmPhase), 32'd0);
    check_eq({tag, "_done"},  32'(done), 32'd0);
    check_eq({tag, "_mism"},  32'(mismatch), 32'd0);
    check_eq({tag, "_abort"}, 32'(abort), 32'd0);
  endtask

  initial begin
    int lat;
    rst      = 1'b0;
    reconfig = 1'b0;
    pw       = 4'd0;
    pwButton = 1'b0;
    rdAddr   = 2'd0;
    tick();
    tick();
    check_idle_outputs("rst");
    check_eq("rst_rd", 32'(rdData), 32'd1);
    rst = 1'b1;
    tick();

    // Default contents, 1-cycle read latency
    check_store("rd_default", 16'h4321);

    // Confirmation mismatch leaves store alone and drops back to ENTER1
    pulse_reconfig();
    check_eq("cfg_busy", 32'(busy), 32'd1);
    enter4(4'd7, 4'd0, 4'd9, 4'd5);
    check_eq("mm_conf", 32'(confirmPhase), 32'd1);
    tick();
    enter4(4'd7, 4'd0, 4'd8, 4'd5);
    check_eq("mm_pulse", 32'(mismatch), 32'd1);
    check_eq("mm_busy", 32'(busy), 32'd1);
    check_eq("mm_conf0", 32'(confirmPhase), 32'd0);
    check_eq("mm_cnt", 32'(digitCount), 32'd0);
    tick();
    check_eq("mm_pulse_end", 32'(mismatch), 32'd0);
    check_store("rd_after_mm", 16'h4321);

    // Retry from ENTER1 with matching entries, commit, then read back
    enter4(4'd7, 4'd0, 4'd9, 4'd5);
    check_eq("ok_conf", 32'(confirmPhase), 32'd1);
    check_eq("ok_cnt", 32'(digitCount), 32'd0);
    tick();
    enter4(4'd7, 4'd0, 4'd9, 4'd5);
    lat = 1;
    while (!done && lat < 20) begin
      tick();
      lat++;
    end
    check_eq("done_lat", 32'(lat), 32'd5);
    check_eq("done_busy", 32'(busy), 32'd0);
    tick();
    check_eq("done_end", 32'(done), 32'd0);
    check_store("rd_new", 16'h5907);

    // Reset during the second COMMIT write cycle restores the default code
    rdAddr = 2'd0;
    pulse_reconfig();
    enter4(4'd8, 4'd6, 4'hA, 4'hB);
    tick();
    enter4(4'd8, 4'd6, 4'hA, 4'hB);
    tick();
    rst = 1'b0;
    #1;
    check_idle_outputs("midrst");
    check_eq("midrst_rd", 32'(rdData), 32'd1);
    tick();
    rst = 1'b1;
    check_store("rd_midrst", 16'h4321);

    // reconfig while busy must not restart the pass
    pulse_reconfig();
    press(4'd3); tick();
    press(4'd4);
    check_eq("ign_cnt_pre", 32'(digitCount), 32'd2);
    pulse_reconfig();
    check_eq("ign_cnt", 32'(digitCount), 32'd2);
    check_eq("ign_busy", 32'(busy), 32'd1);
    lat = 0;
    while (!abort && lat < 30) begin
      tick();
      lat++;
    end
    check_eq("ign_abort", 32'(abort), 32'd1);
    tick();

    // Simultaneous reconfig+press in IDLE, then one press and let it time out
    reconfig = 1'b1;
    pwButton = 1'b1;
    pw       = 4'd5;
    tick();
    reconfig = 1'b0;
    pwButton = 1'b0;
    check_eq("sim_cnt", 32'(digitCount), 32'd0);
    check_eq("sim_busy", 32'(busy), 32'd1);
    press(4'd2);
    check_eq("to_cnt", 32'(digitCount), 32'd1);
    lat = 1;
    while (!abort && lat < 30) begin
      tick();
      lat++;
    end
    check_eq("to_lat", 32'(lat), 32'd10);
    check_eq("to_busy", 32'(busy), 32'd0);
    check_eq("to_cnt0", 32'(digitCount), 32'd0);
    tick();
    check_eq("to_end", 32'(abort), 32'd0);
    check_store("rd_after_to", 16'h4321);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/password_writer.md
Name: password_writer

Overview:
- Owns the 4-digit game password store and programs it.
- Read side feeds the password checker: 2-bit address in, 4-bit digit out, registered with 1-cycle latency. It is a drop-in for the current password ROM.
- Write side: after the checker pulses reconfig, the player enters a new 4-digit code twice through the same pw switches and pwButton. The store is rewritten only if both entries match.

Parameters:
- DEFAULT_PW, 16'h4321, reset contents. Digit i = DEFAULT_PW[4i+3:4i], so the default sequence is 1,2,3,4.
- TIMEOUT_CYCLES, 32'd50_000_000, idle cycles allowed between pwButton presses in an entry state before abort. 0 disables the timeout.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- reconfig  in  1  one-cycle start request from the checker
- pw  in  4  digit switches
- pwButton  in  1  one-cycle debounced press, samples pw
- rdAddr  in  2  checker read address
- rdData  out  4  store[rdAddr], registered
- busy  out  1  high in every state except IDLE
- digitCount  out  2  number of digits accepted in the current pass, for display
- confirmPhase  out  1  high while in ENTER2
- done  out  1  one-cycle pulse when the commit finishes
- mismatch  out  1  one-cycle pulse when the confirmation fails
- abort  out  1  one-cycle pulse on timeout

Behaviour:
- Reset (async, rst==0):
  - state=IDLE; store loaded from DEFAULT_PW.
  - rdData=DEFAULT_PW[3:0]; busy, digitCount, confirmPhase, done, mismatch, abort = 0.
  - Shadow buffer = 0; idle counter = 0; mismatch flag = 0.
- Read port: rdData <= store[rdAddr] every cycle in all states.
  - During COMMIT, rdData may show a mix of old and new digits; busy=1 marks it invalid.
- IDLE: reconfig=1 -> ENTER1, digitCount=0. pwButton is ignored.
- ENTER1: on pwButton, shadow[digitCount] <= pw and digitCount++.
  - On the 4th press (digitCount==3): digitCount wraps to 0, go to ENTER2 with confirmPhase=1 and the mismatch flag cleared.
- ENTER2: on pwButton, if pw != shadow[digitCount] set the sticky mismatch flag; digitCount++.
  - On the 4th press, the flag is evaluated including this digit:
    - Flag clear -> COMMIT.
    - Flag set -> mismatch pulse next cycle, return to ENTER1, digitCount=0, confirmPhase=0. Store untouched.
- COMMIT: 4 cycles; write store[k] <= shadow[k] for k=0..3, one per cycle.
  - Next state is IDLE; done pulses in the first IDLE cycle.
  - pwButton, reconfig and the timeout are ignored here.
  - Latency from the 8th press to done is 5 cycles.
- Timeout:
  - The idle counter runs in ENTER1 and ENTER2 and resets on each pwButton and on each state entry.
  - When it reaches TIMEOUT_CYCLES-1: abort pulse, go to IDLE, digitCount=0, confirmPhase=0, store unchanged.
  - If pwButton arrives in the same cycle, the press wins and the counter resets.
- reconfig while busy: ignored. It never restarts a pass.
- Simultaneous reconfig and pwButton in IDLE: enter ENTER1; the press is not recorded.
- Reset mid-entry or mid-COMMIT: store returns to DEFAULT_PW. A partial commit is never retained.
- Pulses (done, mismatch, abort) are mutually exclusive and registered.

Decomposition:
- Shared package/header:
  - State encodings IDLE=0, ENTER1=1, ENTER2=2, COMMIT=3.
  - PW_DIGITS=4, DIGIT_W=4.
  - DEFAULT_PW value, so the checker and the writer agree.
- Sub-module pw_store: 4x4 register file with one synchronous write port and one registered read port. Its async-reset contents come from a parameter. The sequencer FSM, shadow buffer and timeout counter stay in password_writer.

Test Plan:
- Reset, then read addr 0..3 -> rdData = 1,2,3,4, each 1 cycle after rdAddr changes. busy=0.
- reconfig, enter 7,0,9,5 then 7,0,9,5 -> confirmPhase rises after the 4th press; done pulses 5 cycles after the 8th press; reads return 7,0,9,5.
- reconfig, enter 7,0,9,5 then 7,0,8,5 -> mismatch pulse after the 8th press; state back to ENTER1; reads still 1,2,3,4.
- TIMEOUT_CYCLES=10: reconfig, one press, no further presses -> abort 10 cycles after that press; busy=0; store unchanged.
- Assert rst low during the 2nd COMMIT write cycle -> store immediately reads 1,2,3,4 after release; all outputs 0.
- reconfig pulsed during ENTER1 with 2 digits entered -> ignored; digitCount stays 2.
